// File: rtl/shift_left_pipe.sv
// Four-stage pipelined 16-bit left shifter (SLL / ROL by 0..15).
// Stage k applies a 2^k shift when amount bit k is set; valid/ready handshake on both sides.
module shift_left_pipe (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_flush,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [15:0] i_shift_in,
   input  logic [3:0]  i_shift_val,
   input  logic        i_mode,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [15:0] o_shift_out,
   output logic        o_zero
);

   localparam int WIDTH  = 16;
   localparam int STAGES = 4;

   // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
   // Producers hold valid and payload stable until that edge; ready never depends on
   // the same side's valid, so there is no combinational loop through either port.

   logic [WIDTH-1:0] r_data [STAGES];
   logic [3:0]       r_amt  [STAGES];
   logic             r_mode [STAGES];
   logic [STAGES-1:0] r_vld;

   logic [WIDTH-1:0] w_src_data [STAGES];
   logic [3:0]       w_src_amt  [STAGES];
   logic             w_src_mode [STAGES];
   logic [STAGES-1:0] w_src_vld;
   logic [WIDTH-1:0] w_shift [STAGES];

   logic w_load_0;
   logic w_load_1;
   logic w_load_2;
   logic w_load_3;
   logic [STAGES-1:0] w_load;

   function automatic logic [WIDTH-1:0] f_stage(
      input logic [WIDTH-1:0] d,
      input logic             en,
      input logic             rol,
      input int unsigned      sh
   );
      logic [WIDTH-1:0] w_sll;
      logic [WIDTH-1:0] w_wrap;
      w_sll  = d << sh;
      w_wrap = rol ? (d >> (WIDTH - sh)) : '0;
      return en ? (w_sll | w_wrap) : d;
   endfunction

   // A stage may load when it is empty or its contents move on this edge;
   // chaining the terms lets bubbles collapse behind a stalled tail.
   assign w_load_3 = !r_vld[3] || i_out_ready;
   assign w_load_2 = !r_vld[2] || w_load_3;
   assign w_load_1 = !r_vld[1] || w_load_2;
   assign w_load_0 = !r_vld[0] || w_load_1;
   assign w_load   = {w_load_3, w_load_2, w_load_1, w_load_0};

   assign o_in_ready = w_load_0 && !i_flush;

   always_comb begin
      w_src_data[0] = i_shift_in;
      w_src_amt[0]  = i_shift_val;
      w_src_mode[0] = i_mode;
      w_src_vld[0]  = i_in_valid;
      for (int k = 1; k < STAGES; k++) begin
         w_src_data[k] = r_data[k-1];
         w_src_amt[k]  = r_amt[k-1];
         w_src_mode[k] = r_mode[k-1];
         w_src_vld[k]  = r_vld[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      assign w_shift[k] = f_stage(w_src_data[k], w_src_amt[k][k], w_src_mode[k],
                                  32'(1) << k);
   end

   // Payload registers only capture when a valid operation arrives, so a
   // stalled or emptied stage keeps defined, bit-stable contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int k = 0; k < STAGES; k++) begin
            r_data[k] <= '0;
            r_amt[k]  <= '0;
            r_mode[k] <= 1'b0;
         end
      end else if (i_flush) begin
         r_vld <= '0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (w_load[k]) begin
               r_vld[k] <= w_src_vld[k];
               if (w_src_vld[k]) begin
                  r_data[k] <= w_shift[k];
                  r_amt[k]  <= w_src_amt[k];
                  r_mode[k] <= w_src_mode[k];
               end
            end
         end
      end
   end

   assign o_out_valid = r_vld[3];
   assign o_shift_out = r_data[3];
   assign o_zero      = r_vld[3] && (r_data[3] == '0);

endmodule

// File: tb/tb_shift_left_pipe.sv
// Directed self-checking bench for shift_left_pipe: latency, streaming,
// backpressure, flush and asynchronous reset.
module tb_shift_left_pipe;

  logic        clk;
  logic        rst_n;
  logic        i_flush;
  logic        i_in_valid;
  logic        o_in_ready;
  logic [15:0] i_shift_in;
  logic [3:0]  i_shift_val;
  logic        i_mode;
  logic        o_out_valid;
  logic        i_out_ready;
  logic [15:0] o_shift_out;
  logic        o_zero;

  int cnt_cmp = 0;
  int cnt_err = 0;

  shift_left_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_shift_in  (i_shift_in),
    .i_shift_val (i_shift_val),
    .i_mode      (i_mode),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_shift_out (o_shift_out),
    .o_zero      (o_zero)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; i_flush = 1'b0; i_in_valid = 1'b0; i_shift_in = '0;
    i_shift_val = '0; i_mode = 1'b0; i_out_ready = 1'b1;
    #12;
    cnt_cmp++;
    if (o_out_valid !== 1'b0 || o_shift_out !== 16'h0000 || o_zero !== 1'b0) begin
      cnt_err++;
      $display("FAIL reset_outputs: got v=%b d=%h z=%b expected v=0 d=0000 z=0",
               o_out_valid, o_shift_out, o_zero);
    end
    rst_n = 1'b1;
    #1;
    cnt_cmp++;
    if (o_in_ready !== 1'b1) begin
      cnt_err++;
      $display("FAIL reset_in_ready: got %b expected 1", o_in_ready);
    end
  endtask

  // single op with out_ready = 1: check exact 4-edge latency
  task automatic do_single(input string name, input logic [15:0] d, input logic [3:0] amt,
                           input logic mode, input logic [15:0] exp_d, input logic exp_z);
    @(posedge clk); #1;
    i_in_valid = 1'b1; i_shift_in = d; i_shift_val = amt; i_mode = mode;
    #1;
    cnt_cmp++;
    if (o_in_ready !== 1'b1) begin
      cnt_err++;
      $display("FAIL %s_in_ready: got %b expected 1", name, o_in_ready);
    end
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk); #1;
      cnt_cmp++;
      if (e < 3) begin
        if (o_out_valid !== 1'b0) begin
          cnt_err++;
          $display("FAIL %s_early_valid: edge +%0d got %b expected 0", name, e, o_out_valid);
        end
      end else begin
        if (o_out_valid !== 1'b1 || o_shift_out !== exp_d || o_zero !== exp_z) begin
          cnt_err++;
          $display("FAIL %s_result: got v=%b d=%h z=%b expected v=1 d=%h z=%b",
                   name, o_out_valid, o_shift_out, o_zero, exp_d, exp_z);
        end
      end
    end
    @(posedge clk); #1;
    cnt_cmp++;
    if (o_out_valid !== 1'b0) begin
      cnt_err++;
      $display("FAIL %s_drain: got out_valid %b expected 0", name, o_out_valid);
    end
  endtask

  task automatic test_single_ops();
    do_single("sll_1_15",   16'h0001, 4'd15, 1'b0, 16'h8000, 1'b0);
    do_single("sll_abcd_4", 16'hABCD, 4'd4,  1'b0, 16'hBCD0, 1'b0);
    do_single("rol_abcd_4", 16'hABCD, 4'd4,  1'b1, 16'hBCDA, 1'b0);
    do_single("rol_8001_1", 16'h8001, 4'd1,  1'b1, 16'h0003, 1'b0);
  endtask

  task automatic test_zero_passthru();
    do_single("sll_zero",   16'h8000, 4'd1, 1'b0, 16'h0000, 1'b1);
    do_single("sll_pass",   16'h1234, 4'd0, 1'b0, 16'h1234, 1'b0);
    do_single("rol_pass",   16'h1234, 4'd0, 1'b1, 16'h1234, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      i_in_valid = (c < 16);
      i_shift_in = 16'h0001; i_shift_val = 4'(c); i_mode = 1'b1;
      #1;
      if (c < 16) begin
        cnt_cmp++;
        if (o_in_ready !== 1'b1) begin
          cnt_err++;
          $display("FAIL stream_in_ready: cycle %0d got %b expected 1", c, o_in_ready);
        end
      end
      @(posedge clk); #1;
      cnt_cmp++;
      if (c >= 3 && c <= 18) begin
        exp_d = 16'h0001 << (c - 3);
        if (o_out_valid !== 1'b1 || o_shift_out !== exp_d || o_zero !== 1'b0) begin
          cnt_err++;
          $display("FAIL stream_result: cycle %0d got v=%b d=%h z=%b expected v=1 d=%h z=0",
                   c, o_out_valid, o_shift_out, o_zero, exp_d);
        end
      end else if (o_out_valid !== 1'b0) begin
        cnt_err++;
        $display("FAIL stream_idle: cycle %0d got out_valid %b expected 0", c, o_out_valid);
      end
    end
    i_in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_q[$];
    logic [15:0] exp_d;
    logic        exp_rdy;
    logic [3:0]  amts [6];
    amts = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd1, 4'd2};
    exp_q = {16'h0018, 16'h00C0, 16'h0600, 16'h3000};
    i_out_ready = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 6; j++) begin
      i_in_valid = 1'b1; i_shift_in = 16'h0003; i_shift_val = amts[j]; i_mode = 1'b0;
      #1;
      exp_rdy = (j < 4);
      cnt_cmp++;
      if (o_in_ready !== exp_rdy) begin
        cnt_err++;
        $display("FAIL bp_in_ready: cycle %0d got %b expected %b", j, o_in_ready, exp_rdy);
      end
      @(posedge clk); #1;
      if (j >= 3) begin
        cnt_cmp++;
        if (o_out_valid !== 1'b1 || o_shift_out !== 16'h0018 || o_zero !== 1'b0) begin
          cnt_err++;
          $display("FAIL bp_hold: cycle %0d got v=%b d=%h z=%b expected v=1 d=0018 z=0",
                   j, o_out_valid, o_shift_out, o_zero);
        end
      end
    end
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = exp_q.pop_front();
      cnt_cmp++;
      if (o_out_valid !== 1'b1 || o_shift_out !== exp_d) begin
        cnt_err++;
        $display("FAIL bp_drain: item %0d got v=%b d=%h expected v=1 d=%h",
                 k, o_out_valid, o_shift_out, exp_d);
      end
      @(posedge clk); #1;
    end
    cnt_cmp++;
    if (o_out_valid !== 1'b0) begin
      cnt_err++;
      $display("FAIL bp_no_dup: got out_valid %b expected 0", o_out_valid);
    end
  endtask

  task automatic test_flush();
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    for (int j = 0; j < 3; j++) begin
      i_in_valid = 1'b1; i_shift_in = 16'h0101; i_shift_val = 4'(j + 1); i_mode = 1'b0;
      @(posedge clk); #1;
    end
    i_flush = 1'b1; i_in_valid = 1'b1; i_shift_in = 16'h7777; i_shift_val = 4'd1;
    #1;
    cnt_cmp++;
    if (o_in_ready !== 1'b0) begin
      cnt_err++;
      $display("FAIL flush_in_ready: got %b expected 0", o_in_ready);
    end
    @(posedge clk); #1;
    i_flush = 1'b0; i_in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cnt_cmp++;
      if (o_out_valid !== 1'b0) begin
        cnt_err++;
        $display("FAIL flush_quiet: cycle %0d got out_valid %b expected 0", c, o_out_valid);
      end
      @(posedge clk); #1;
    end
    do_single("post_flush", 16'h00F0, 4'd8, 1'b0, 16'hF000, 1'b0);
  endtask

  task automatic test_async_reset();
    i_out_ready = 1'b0;
    @(posedge clk); #1;
    for (int j = 0; j < 4; j++) begin
      i_in_valid = 1'b1; i_shift_in = 16'h00FF; i_shift_val = 4'(j + 1); i_mode = 1'b1;
      @(posedge clk); #1;
    end
    i_in_valid = 1'b0;
    cnt_cmp++;
    if (o_out_valid !== 1'b1 || o_shift_out !== 16'h01FE) begin
      cnt_err++;
      $display("FAIL arst_full: got v=%b d=%h expected v=1 d=01fe", o_out_valid, o_shift_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    cnt_cmp++;
    if (o_out_valid !== 1'b0 || o_shift_out !== 16'h0000 || o_zero !== 1'b0) begin
      cnt_err++;
      $display("FAIL arst_immediate: got v=%b d=%h z=%b expected v=0 d=0000 z=0",
               o_out_valid, o_shift_out, o_zero);
    end
    #2;
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      cnt_cmp++;
      if (o_out_valid !== 1'b0) begin
        cnt_err++;
        $display("FAIL arst_after: cycle %0d got out_valid %b expected 0", c, o_out_valid);
      end
    end
    do_single("post_reset", 16'h0F00, 4'd8, 1'b1, 16'h000F, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_ops();
    test_zero_passthru();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt_cmp, cnt_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_left_pipe.md
# shift_left_pipe

Four-stage pipelined 16-bit left shifter: logical shift left (SLL) or rotate left (ROL) by 0–15 bits. One stage per shift-amount bit, with a valid/ready handshake on both sides. It sits beside the combinational arithmetic-right shifter in the ALU datapath and provides the left-direction shift for multi-cycle execute. Throughput is one operation per cycle; latency is 4 cycles when unstalled.

## Interface
- WIDTH, 16, data width; fixed at 16, shift amount width is log2(WIDTH)=4
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; invalidates all stages
- in_valid  input  1  upstream offers an operation
- in_ready  output  1  block accepts the operation this cycle
- shift_in  input  16  operand
- shift_val  input  4  shift amount, 0–15
- mode  input  1  0 = SLL (zero fill), 1 = ROL (bits leaving bit 15 re-enter at bit 0)
- out_valid  output  1  shift_out holds a result
- out_ready  input  1  downstream accepts the result
- shift_out  output  16  result
- zero  output  1  shift_out == 0, qualified by out_valid

## Operation
- Accept: in_valid && in_ready at a rising edge captures the operand into stage 0.
- Stages S0..S3 each hold: data[15:0], remaining amount bits, mode, vld.
- Stage k shifts its input left by 2^k when amount bit k is 1, and passes it unchanged otherwise:
  - S0 uses shift_val[0] on shift_in.
  - S1 uses bit 1, S2 uses bit 2, S3 uses bit 3, each on the previous stage's register.
- SLL: vacated low bits are 0; bits shifted past bit 15 are discarded.
- ROL: bit i moves to bit (i + 2^k) mod 16.
- S3 registers drive shift_out, out_valid (= S3.vld) and zero (= S3.vld && S3.data == 0).
- Stall, per stage: stage k loads when !S(k).vld || advance(k+1); S3 advances when out_ready.
  - in_ready = !S0.vld || advance(1), computed combinationally.
  - Bubbles collapse: an empty stage loads even when a later stage is stalled.
- A stage that gives up its contents without loading new data clears its vld.
- A stage holding data keeps data, amount and mode bit-stable while stalled.
- shift_val = 0 passes the operand through unchanged in both modes.

## Timing
- Reset (rst_n low, asynchronous): all vld = 0, all data = 0, out_valid = 0, shift_out = 0x0000, zero = 0.
  - in_ready is 1 once rst_n is high.
- Reset asserted mid-operation discards every in-flight operation immediately; no partial result is produced.
- Latency: accept at edge N gives out_valid = 1 after edge N+3, i.e. the result is visible 4 edges after the accepting edge counts S0..S3.
- Back-to-back accepts yield results on consecutive cycles, in order.
- out_valid with !out_ready: shift_out and zero hold stable until the handshake completes.
- Full pipeline stall (all four vld, out_ready = 0): in_ready = 0 in the same cycle.
- Full pipe with out_ready = 1: in_ready = 1; a simultaneous accept and emit keeps four in flight.
- flush: at the edge, all vld clear and any concurrent in_valid is ignored.
  - in_ready is forced to 0 during flush.
  - flush has priority over every load.
- flush and rst_n together: reset dominates.
- Output is never X after reset; data registers always load defined values.

## Test plan
- Reset then single ops, out_ready = 1: SLL 0x0001 by 15 -> 0x8000; SLL 0xABCD by 4 -> 0xBCD0; ROL 0xABCD by 4 -> 0xBCDA; ROL 0x8001 by 1 -> 0x0003. Each has out_valid exactly 4 edges after accept and zero = 0.
- Zero flag and pass-through: SLL 0x8000 by 1 -> 0x0000 with zero = 1; SLL and ROL 0x1234 by 0 -> 0x1234.
- Streaming: 16 back-to-back ops (0x0001 ROL by 0..15) -> results 0x0001, 0x0002, …, 0x8000 on 16 consecutive cycles, with in_ready high throughout.
- Backpressure: hold out_ready = 0 for 6 cycles with in_valid high -> in_ready drops after 4 accepts and shift_out is stable. Then release -> 4 results in order, no loss or duplication.
- Flush: with 3 ops in flight, assert flush for one cycle alongside in_valid -> out_valid stays 0 afterwards, the concurrent op is not accepted, and the next accepted op emerges at 4-cycle latency.
- Async reset mid-stream: drop rst_n between edges with the pipe full -> out_valid = 0 and shift_out = 0x0000 immediately, without waiting for a clock edge. After release, normal 4-cycle operation resumes.
